// File: rtl/alu_frame_ctrl.sv
// Frame sequencer for the registered ALU: parses 0xCC/0xDD command frames, gates the ALU clock,
// pulses ALU_EN, captures the 16-bit result and returns it low byte first over the TX handshake.
module alu_frame_ctrl #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OPER_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  output logic [OPER_WIDTH-1:0] OPER_A,
  output logic [OPER_WIDTH-1:0] OPER_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_GATE_EN,
  output logic [OPER_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY
);

  localparam logic [OPER_WIDTH-1:0] CMD_FULL  = OPER_WIDTH'(8'hCC);
  localparam logic [OPER_WIDTH-1:0] CMD_REUSE = OPER_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUN, GATE, RUN, WAIT_RES, TX_LO, TX_HI, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [OUT_WIDTH-1:0]  result, result_nxt;
  logic [OPER_WIDTH-1:0] oper_a_nxt, oper_b_nxt, tx_data_nxt;
  logic [3:0]            fun_nxt;
  logic                  tx_vld_nxt, gate_nxt, alu_en_nxt;

  always_comb begin
    state_nxt   = state;
    result_nxt  = result;
    oper_a_nxt  = OPER_A;
    oper_b_nxt  = OPER_B;
    fun_nxt     = ALU_FUN;
    tx_vld_nxt  = TX_D_VLD;
    tx_data_nxt = TX_P_DATA;
    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_FULL)       state_nxt = GET_A;
          else if (RX_P_DATA == CMD_REUSE) state_nxt = GET_FUN;
        end
      end
      GET_A: begin
        if (RX_D_VLD) begin
          oper_a_nxt = RX_P_DATA;
          state_nxt  = GET_B;
        end
      end
      GET_B: begin
        if (RX_D_VLD) begin
          oper_b_nxt = RX_P_DATA;
          state_nxt  = GET_FUN;
        end
      end
      GET_FUN: begin
        if (RX_D_VLD) begin
          fun_nxt   = RX_P_DATA[3:0];
          state_nxt = GATE;
        end
      end
      GATE: state_nxt = RUN;
      RUN:  state_nxt = WAIT_RES;
      WAIT_RES: begin
        if (ALU_OUT_VLD) begin
          result_nxt = ALU_OUT;
          state_nxt  = TX_LO;
          // Low byte can go out on the same edge as the capture if the TX is free.
          if (!TX_BUSY) begin
            tx_vld_nxt  = 1'b1;
            tx_data_nxt = ALU_OUT[OPER_WIDTH-1:0];
          end
        end
      end
      TX_LO: begin
        if (TX_D_VLD) begin
          if (TX_BUSY) begin
            tx_vld_nxt = 1'b0;
            state_nxt  = TX_HI;
          end
        end else if (!TX_BUSY) begin
          tx_vld_nxt  = 1'b1;
          tx_data_nxt = result[OPER_WIDTH-1:0];
        end
      end
      TX_HI: begin
        if (TX_D_VLD) begin
          if (TX_BUSY) begin
            tx_vld_nxt = 1'b0;
            state_nxt  = DONE;
          end
        end else if (!TX_BUSY) begin
          tx_vld_nxt  = 1'b1;
          tx_data_nxt = result[OUT_WIDTH-1:OPER_WIDTH];
        end
      end
      DONE: begin
        if (!TX_BUSY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Gate and enable are decoded from the next state so they leave a flop.
    gate_nxt   = (state_nxt == GATE) || (state_nxt == RUN) || (state_nxt == WAIT_RES);
    alu_en_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      result      <= '0;
      OPER_A      <= '0;
      OPER_B      <= '0;
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      state       <= state_nxt;
      result      <= result_nxt;
      OPER_A      <= oper_a_nxt;
      OPER_B      <= oper_b_nxt;
      ALU_FUN     <= fun_nxt;
      ALU_EN      <= alu_en_nxt;
      CLK_GATE_EN <= gate_nxt;
      TX_P_DATA   <= tx_data_nxt;
      TX_D_VLD    <= tx_vld_nxt;
    end
  end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Bench for alu_frame_ctrl: emulates the ALU and UART transmitter, checks outputs every cycle
// against a byte-level frame model and pins the model with hand-computed literals.
module tb_alu_frame_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  OPER_A, OPER_B, TX_P_DATA;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, CLK_GATE_EN, TX_D_VLD, TX_BUSY;

  alu_frame_ctrl #(.OPER_WIDTH(8), .OUT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .OPER_A(OPER_A), .OPER_B(OPER_B),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn);
    case (fn)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      4'd2:    return {8'h00, a} * {8'h00, b};
      4'd4:    return {8'h00, a & b};
      4'd5:    return {8'h00, a | b};
      default: return 16'h0000;
    endcase
  endfunction

  // ALU emulator: registered, result one cycle after ALU_EN.
  initial begin
    logic       en;
    logic [7:0] a, b;
    logic [3:0] fn;
    ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
    forever begin
      @(negedge CLK);
      en = ALU_EN; a = OPER_A; b = OPER_B; fn = ALU_FUN;
      @(posedge CLK); #1;
      ALU_OUT_VLD = en && RST;
      if (en) ALU_OUT = alu_f(a, b, fn);
    end
  end

  // Transmitter emulator: busy for 3 cycles per accepted byte, or forced by hold.
  logic hold = 1'b0;
  initial begin
    logic v;
    int   cnt = 0;
    TX_BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      v = TX_D_VLD;
      @(posedge CLK); #1;
      if (!RST)               cnt = 0;
      else if (cnt > 0)       cnt--;
      else if (v && !TX_BUSY) cnt = 3;
      TX_BUSY = hold || (cnt > 0);
    end
  end

  // Frame model: byte-level parse, expected TX bytes, expected gate/enable window.
  int         mst = 0;
  logic [7:0] ma = 0, mb = 0;
  logic [3:0] mfun = 0;
  logic       active = 0;
  int         s_cyc = -100;
  int         n_acc = 0;
  int         k_cyc = 0;
  logic       done2 = 0;
  logic [7:0] tx_q[$];
  logic [7:0] got[$];

  initial begin
    logic prev_vld = 0, prev_busy = 0, prev_acc = 0, acc;
    logic [7:0]  prev_data = 0;
    logic [15:0] r;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        mst = 0; ma = 0; mb = 0; mfun = 0; active = 0; s_cyc = -100;
        n_acc = 0; done2 = 0; tx_q.delete();
        prev_vld = 0; prev_busy = 0; prev_acc = 0; prev_data = 0;
      end else begin
        check("clk_gate_en", CLK_GATE_EN, (cyc >= s_cyc) && (cyc <= s_cyc + 2));
        check("alu_en", ALU_EN, cyc == s_cyc + 1);
        check("oper_a", OPER_A, ma);
        check("oper_b", OPER_B, mb);
        check("alu_fun", ALU_FUN, mfun);
        if (TX_D_VLD && !prev_vld) check("tx_rise_while_busy", prev_busy, 0);
        if (prev_acc) check("tx_drop_after_accept", TX_D_VLD, 0);
        if (TX_D_VLD && prev_vld && !prev_busy) check("tx_data_stable", TX_P_DATA, prev_data);
        acc = TX_D_VLD && TX_BUSY;
        if (acc) begin
          got.push_back(TX_P_DATA);
          check("tx_byte_expected", tx_q.size() > 0, 1);
          if (tx_q.size() > 0) check("tx_byte", TX_P_DATA, tx_q.pop_front());
          n_acc++;
          if (n_acc == 2) begin done2 = 1; k_cyc = cyc + 1; end
        end
        if (RX_D_VLD && !active) begin
          case (mst)
            0: if (RX_P_DATA == 8'hCC) mst = 1; else if (RX_P_DATA == 8'hDD) mst = 3;
            1: begin ma = RX_P_DATA; mst = 2; end
            2: begin mb = RX_P_DATA; mst = 3; end
            default: begin
              mfun = RX_P_DATA[3:0]; mst = 0;
              s_cyc = cyc + 1; active = 1; n_acc = 0; done2 = 0;
              r = alu_f(ma, mb, RX_P_DATA[3:0]);
              tx_q.push_back(r[7:0]);
              tx_q.push_back(r[15:8]);
            end
          endcase
        end
        if (active && done2 && !TX_BUSY && cyc >= k_cyc) active = 0;
        prev_vld = TX_D_VLD; prev_busy = TX_BUSY; prev_data = TX_P_DATA; prev_acc = acc;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b; RX_D_VLD = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (active && t < 300) begin @(posedge CLK); #1; t++; end
    check("op_completes_in_budget", active, 0);
  endtask

  task automatic expect_tx(input string name, input logic [7:0] lo, input logic [7:0] hi);
    check({name, "_nbytes"}, got.size(), 2);
    if (got.size() == 2) begin
      check({name, "_lo"}, got[0], lo);
      check({name, "_hi"}, got[1], hi);
    end
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vld_hi;
    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0;
    #3;
    check("rst_oper_a", OPER_A, 0);
    check("rst_tx_vld", TX_D_VLD, 0);
    check("rst_gate", CLK_GATE_EN, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;

    // Add
    send(8'hCC); send(8'h12); send(8'h34); send(8'h00);
    wait_idle();
    check("add_oper_a", OPER_A, 8'h12);
    check("add_oper_b", OPER_B, 8'h34);
    expect_tx("add", 8'h46, 8'h00);

    // Multiply, then reuse operands with subtract
    send(8'hCC); send(8'hFF); send(8'hFF); send(8'h02);
    wait_idle();
    expect_tx("mul", 8'h01, 8'hFE);
    send(8'hDD); send(8'h01);
    wait_idle();
    expect_tx("reuse_sub", 8'h00, 8'h00);
    check("reuse_oper_a", OPER_A, 8'hFF);
    check("reuse_oper_b", OPER_B, 8'hFF);

    // Bad command, then upper FUN bits ignored
    send(8'h55);
    repeat (5) begin @(posedge CLK); #1; end
    check("bad_cmd_no_tx", got.size(), 0);
    send(8'hDD); send(8'hF4);
    check("fun_upper_ignored", ALU_FUN, 4'h4);
    wait_idle();
    expect_tx("and", 8'hFF, 8'h00);

    // TX backpressure across the capture
    send(8'hCC); send(8'h12); send(8'h34); send(8'h00);
    hold = 1'b1;
    vld_hi = 0;
    repeat (22) begin @(negedge CLK); if (TX_D_VLD) vld_hi++; end
    check("backpressure_no_vld", vld_hi, 0);
    @(posedge CLK); #1 hold = 1'b0;
    wait_idle();
    expect_tx("backpressure", 8'h46, 8'h00);

    // Byte strobed during WAIT_RES is dropped
    send(8'hCC); send(8'h01); send(8'h02); send(8'h00);
    @(posedge CLK); #1;
    send(8'hCC);
    wait_idle();
    expect_tx("drop", 8'h03, 8'h00);
    send(8'hDD); send(8'h01);
    wait_idle();
    expect_tx("after_drop", 8'hFF, 8'hFF);

    // Reset mid-frame
    send(8'hCC); send(8'h12);
    #2 RST = 1'b0;
    #1;
    check("midrst_oper_a", OPER_A, 0);
    check("midrst_oper_b", OPER_B, 0);
    check("midrst_fun", ALU_FUN, 0);
    check("midrst_tx_data", TX_P_DATA, 0);
    check("midrst_tx_vld", TX_D_VLD, 0);
    check("midrst_alu_en", ALU_EN, 0);
    check("midrst_gate", CLK_GATE_EN, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    got.delete();
    send(8'hCC); send(8'h01); send(8'h01); send(8'h00);
    wait_idle();
    expect_tx("post_reset", 8'h02, 8'h00);

    check("tx_queue_drained", tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
